// File: rtl/fifo_arbiter.sv
// rtl/fifo_arbiter.sv - round-robin push arbiter and flush sequencer in front of a shared FIFO
// Define FIFO_ARB_STATS_EN to add saturating per-producer push counters on push_cnt.
module fifo_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 2
`ifdef FIFO_ARB_STATS_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] data,
  output logic [NREQ-1:0]        gnt,
  input  logic                   cons_pop,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   busy,
  output logic [DATA_W-1:0]      fifo_din,
  output logic                   fifo_push,
  output logic                   fifo_pop,
  input  logic                   fifo_empty,
  input  logic                   fifo_full
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]  push_cnt
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, gnt_idx, cand;
  logic             found;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ARB;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      done_q <= (state == FLUSH) && fifo_empty;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (flush) state_nxt = FLUSH;
      FLUSH:   if (fifo_empty) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    // Scan in cyclic order starting at ptr; first requester wins.
    if (reset && (state == ARB) && !flush && !fifo_full) begin
      for (int i = 0; i < NREQ; i++) begin
        cand = PTR_W'((int'(ptr) + i) % NREQ);
        if (!found && req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end

    gnt      = '0;
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (found && (gnt_idx == PTR_W'(i))) begin
        gnt[i]   = 1'b1;
        fifo_din = data[i*DATA_W +: DATA_W];
      end
    end

    fifo_push  = found;
    ptr_nxt    = found ? ((gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1)) : ptr;
    busy       = reset && (state == FLUSH);
    fifo_pop   = reset && ((state == FLUSH) ? !fifo_empty : (cons_pop && !flush));
    flush_done = reset && done_q;
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign push_cnt = reset ? cnt_q : '0;
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb/tb_fifo_arbiter.sv - self-checking bench for fifo_arbiter with a depth-2 FIFO model
// Stats checks are compiled in when FIFO_ARB_STATS_EN is defined.
module tb_fifo_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 2;
`ifdef FIFO_ARB_STATS_EN
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`else
  localparam int CNT_MAX = 255;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset, cons_pop, flush, fifo_empty, fifo_full;
  logic [NREQ-1:0]        req, gnt;
  logic [NREQ*DATA_W-1:0] data;
  logic                   flush_done, busy, fifo_push, fifo_pop;
  logic [DATA_W-1:0]      fifo_din;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*CNT_W-1:0]  push_cnt;
`endif

  fifo_arbiter #(
    .NREQ(NREQ),
    .DATA_W(DATA_W)
`ifdef FIFO_ARB_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .data(data),
    .gnt(gnt),
    .cons_pop(cons_pop),
    .flush(flush),
    .flush_done(flush_done),
    .busy(busy),
    .fifo_din(fifo_din),
    .fifo_push(fifo_push),
    .fifo_pop(fifo_pop),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full)
`ifdef FIFO_ARB_STATS_EN
    ,
    .push_cnt(push_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents, mode, pointer, pending done pulse, counters.
  logic [DATA_W-1:0] fq[$];
  int                m_ptr = 0;
  bit                m_flush = 1'b0;
  bit                m_done = 1'b0;
  int                m_cnt[NREQ];
  logic [NREQ-1:0]   pre_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int p, input logic [NREQ-1:0] r);
    for (int j = 0; j < NREQ; j++) begin
      if (r[(p + j) % NREQ]) return (p + j) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick_x(input int xg, input int xd, input int xbp);
    int k;
    logic [31:0] ed, ep;
    bit p_push, p_pop, p_reset, p_flush, p_empty;
    logic [DATA_W-1:0] p_din;
    #2;
    k = -1;
    if (reset && !m_flush && !flush && !fifo_full) k = pick(m_ptr, req);
    ed = '0;
    if (k >= 0) ed = 32'(data[k*DATA_W +: DATA_W]);
    if (!reset)       ep = 0;
    else if (m_flush) ep = 32'(!fifo_empty);
    else              ep = 32'(cons_pop && !flush);
    chk("gnt", 32'(gnt), (k >= 0) ? (32'd1 << k) : 32'd0);
    chk("fifo_push", 32'(fifo_push), 32'(k >= 0));
    chk("fifo_din", 32'(fifo_din), ed);
    chk("fifo_pop", 32'(fifo_pop), ep);
    chk("busy", 32'(busy), 32'(reset && m_flush));
    chk("flush_done", 32'(flush_done), 32'(reset && m_done));
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      chk("push_cnt", 32'(push_cnt[i*CNT_W +: CNT_W]), reset ? 32'(m_cnt[i]) : 32'd0);
`endif
    if (xg >= 0) chk("plan_gnt", 32'(gnt), 32'(xg));
    if (xd >= 0) chk("plan_din", 32'(fifo_din), 32'(xd));
    if (xbp >= 0) begin
      chk("plan_busy", 32'(busy), 32'(xbp >> 1));
      chk("plan_pop", 32'(fifo_pop), 32'(xbp & 1));
    end
    p_push = fifo_push; p_pop = fifo_pop; p_din = fifo_din; pre_gnt = gnt;
    p_reset = reset; p_flush = flush; p_empty = fifo_empty;
    @(posedge clk);
    #1;
    if (!p_reset) begin
      fq.delete();
      m_flush = 1'b0; m_ptr = 0; m_done = 1'b0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else begin
      if (p_pop && fq.size() > 0) void'(fq.pop_front());
      if (p_push && fq.size() < DEPTH) fq.push_back(p_din);
      if (!m_flush) begin
        m_done = 1'b0;
        if (p_flush) m_flush = 1'b1;
        else if (k >= 0) begin
          m_ptr = (k + 1) % NREQ;
          if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
        end
      end else begin
        m_done = p_empty;
        if (p_empty) m_flush = 1'b0;
      end
    end
    fifo_empty = (fq.size() == 0);
    fifo_full  = (fq.size() == DEPTH);
  endtask

  task automatic tick();
    tick_x(-1, -1, -1);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    reset = 1'b0; req = 4'hf; data = 8'he4; cons_pop = 1'b0; flush = 1'b0;
    fifo_empty = 1'b1; fifo_full = 1'b0;

    // Reset held two cycles with all requests up, then first grant to producer 0.
    tick_x(0, 0, 0);
    tick_x(0, 0, 0);
    reset = 1'b1;
    tick_x(1, 0, -1);

    // Round-robin with a consumer popping every cycle.
    reset = 1'b0; tick(); reset = 1'b1;
    cons_pop = 1'b1;
    for (int i = 0; i < 5; i++) tick_x(1 << (i % 4), i % 4, -1);

    // Back-pressure from a full FIFO.
    reset = 1'b0; tick(); reset = 1'b1;
    req = 4'b0101; cons_pop = 1'b0;
    tick_x(1, 0, -1);
    tick_x(4, 2, -1);
    tick_x(0, 0, -1);
    tick_x(0, 0, -1);
    cons_pop = 1'b1;
    tick_x(0, 0, 1);
    cons_pop = 1'b0;
    tick_x(1, 0, -1);

    // Flush of a two-entry FIFO.
    req = 4'hf; flush = 1'b1;
    tick_x(0, 0, 0);
    flush = 1'b0;
    tick_x(0, 0, 3);
    tick_x(0, 0, 3);
    tick_x(0, 0, 2);
    #2 chk("plan_flush_done", 32'(flush_done), 32'd1);
    tick_x(2, 1, 0);
    tick();

    // Reset on the second flush cycle aborts without a done pulse.
    flush = 1'b1;
    tick_x(0, 0, 0);
    flush = 1'b0;
    tick_x(0, 0, 3);
    reset = 1'b0;
    tick_x(0, 0, 0);
    reset = 1'b1; req = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick_x(0, 0, -1);
      chk("abort_no_done", 32'(flush_done), 32'd0);
    end

`ifdef FIFO_ARB_STATS_EN
    // Producer 1 alone; its 2-bit counter saturates at 3.
    reset = 1'b0; tick(); reset = 1'b1;
    req = 4'b0010; cons_pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_x(2, 1, -1);
      chk("stats_cnt1", 32'(push_cnt[CNT_W +: CNT_W]), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end
`endif

    // Random traffic; producers hold req/data until granted.
    pre_gnt = '0;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || pre_gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
      cons_pop = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Round-robin push arbiter and drain sequencer that shares a single FiFo instance between NREQ producers and one consumer. It selects at most one producer per cycle and drives the FIFO's din/push, and forwards consumer pops to the FIFO. On request it flushes the FIFO to empty while holding off all producers. It sits directly between the producer blocks and the FIFO's write/read ports.

## Interface
- NREQ, 4, number of producers (2..8)
- DATA_W, 2, payload width; must equal FIFO data width
- CNT_W, 8, width of per-producer statistics counters (FIFO_ARB_STATS_EN only)

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; one clock, reset is synchronous and active-low
- req  input  NREQ  per-producer push request; held with data until granted
- data  input  NREQ*DATA_W  producer payloads; producer i at bits [i*DATA_W +: DATA_W]
- gnt  output  NREQ  one-hot grant; gnt[i]=1 means data i is written at this edge
- cons_pop  input  1  consumer pop request
- flush  input  1  start flush (sampled when state is ARB)
- flush_done  output  1  one-cycle pulse after flush completes
- busy  output  1  high while in FLUSH
- fifo_din  output  DATA_W  to FIFO din
- fifo_push  output  1  to FIFO push
- fifo_pop  output  1  to FIFO pop
- fifo_empty  input  1  from FIFO empty
- fifo_full  input  1  from FIFO full
- push_cnt  output  NREQ*CNT_W  per-producer accepted-push counts (FIFO_ARB_STATS_EN only)

## Operation
- State machine: ARB, FLUSH. Reset -> ARB.
- ARB: if flush=1, no grant this cycle; fifo_pop=0; next state FLUSH. Otherwise, if fifo_full=0 and any req, grant the first requester at or after ptr in cyclic order (ptr, ptr+1, ..., NREQ-1, 0, ...). fifo_push=|gnt; fifo_din=data of the granted producer, or 0 when there is no grant. fifo_pop=cons_pop.
- ptr: round-robin pointer, log2(NREQ) bits, reset 0. When a grant is made to producer k, ptr <= (k+1) mod NREQ. With no grant, ptr holds.
- fifo_full=1: gnt=0, fifo_push=0, ptr holds. A push and a pop in the same cycle are both issued; the FIFO resolves the pair.
- FLUSH: gnt=0, fifo_push=0, cons_pop ignored, busy=1, fifo_pop=!fifo_empty. When fifo_empty=1, next state is ARB and flush_done=1 in the following cycle. flush is ignored while in FLUSH.
- Flush with an already-empty FIFO: one cycle in FLUSH, then ARB, then a flush_done pulse.
- reset=0 at any time, including mid-flush: state ARB, ptr=0, flush_done=0, counters 0; no flush_done is issued for the aborted flush.

## Timing
- gnt, fifo_push, fifo_din, fifo_pop and busy are combinational from state, ptr, req, data, cons_pop, flush and the FIFO flags; zero-cycle grant latency.
- state, ptr, flush_done and push_cnt are registered.
- Outputs during reset (reset=0): gnt=0, fifo_push=0, fifo_pop=0, fifo_din=0, busy=0, flush_done=0, push_cnt=0.
- Producers must hold req and data stable until gnt[i] is seen high at a rising edge. req is deasserted after the grant edge unless the producer has more data to push.
- Throughput: 1 push per cycle when the FIFO is not full. Fairness: each continuously requesting producer is granted within NREQ grants.

## Configuration
- FIFO_ARB_STATS_EN defined: push_cnt port present. Counter i increments on every edge where gnt[i]=1, saturates at 2^CNT_W-1, and is cleared only by reset.
- Not defined: push_cnt port and its counters are absent; all other behaviour is identical.

## Test plan
All scenarios use a FIFO of depth 2 and DATA_W=2.
- Reset: hold reset=0 for 2 cycles with req=4'b1111 -> gnt=0, fifo_push=0, fifo_pop=0, busy=0, flush_done=0; after reset=1, the first grant is gnt=4'b0001.
- Round-robin: req=4'b1111, data={3,2,1,0}, cons_pop=1 every cycle -> grants 0001, 0010, 0100, 1000, 0001 on successive cycles; fifo_din = 0, 1, 2, 3, 0.
- Full back-pressure: req=4'b0101, cons_pop=0 -> grants 0001 then 0100; FIFO becomes full, then gnt=0 and ptr holds. Pulsing cons_pop once -> the next grant goes to producer 0.
- Flush: FIFO holds 2 entries, assert flush for 1 cycle with req=4'b1111 -> busy=1 for 3 cycles with fifo_pop=1, 1, 0 and no grants; flush_done pulses once; grants resume afterwards.
- Reset mid-flush: assert reset=0 on the second FLUSH cycle -> state ARB, busy=0, and no flush_done pulse.
- Stats (FIFO_ARB_STATS_EN, CNT_W=2): producer 1 alone is granted 5 times -> push_cnt[1] reads 1, 2, 3, 3, 3; all other counters stay 0.
